// File: rtl/period_meter.sv
// period_meter: measures the spacing in clk_i cycles between rising edges of strobe_i.
// Latency: period_o/valid_o register on the clock edge that samples the closing strobe edge, so they are visible one cycle later.
// Backpressure: none; valid_o is a one-cycle pulse with no ready, so the consumer must capture it on that cycle.
//
// Ports:
//   clk_i     system clock
//   reset     asynchronous active-low reset
//   strobe_i  strobe to measure (synchronous to clk_i)
//   clear_i   synchronous clear: abort measurement, back to IDLE, drop flags
//   period_o  last reported period in clk_i cycles (N bits)
//   valid_o   one-cycle pulse when period_o is updated
//   locked_o  high while the two most recent raw periods are equal
//   timeout_o sticky, set when the counter saturates without an edge
//
// Optional feature macro: PERIOD_METER_AVG_EN. When defined, period_o reports the
// truncated mean of each block of four measurements instead of every measurement.
module period_meter #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         reset,
    input  logic         strobe_i,
    input  logic         clear_i,
    output logic [N-1:0] period_o,
    output logic         valid_o,
    output logic         locked_o,
    output logic         timeout_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [N-1:0] CTR_MAX = '1;

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] ctr;
    logic [N-1:0] ctr_nx;
    logic [N-1:0] period_nx;
    logic         valid_nx;
    logic         locked_nx;
    logic         timeout_nx;
    logic         strobe_d;
    logic         edge_det;
    // Set once a measurement exists since the last arming edge; gates lock.
    logic         have_prev;
    logic         have_prev_nx;

`ifdef PERIOD_METER_AVG_EN
    // Lock compares raw periods, which period_o no longer holds in this mode.
    logic [N-1:0] last_raw;
    logic [N-1:0] last_raw_nx;
    logic [N+1:0] acc;
    logic [N+1:0] acc_nx;
    logic [N+1:0] sum;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nx;
`endif

    // A level held high yields only one edge because strobe_d follows it.
    assign edge_det = strobe_i & ~strobe_d;

    always_comb begin
        state_nx     = state;
        ctr_nx       = ctr;
        period_nx    = period_o;
        valid_nx     = 1'b0;
        locked_nx    = locked_o;
        timeout_nx   = timeout_o;
        have_prev_nx = have_prev;
`ifdef PERIOD_METER_AVG_EN
        last_raw_nx  = last_raw;
        acc_nx       = acc;
        cnt_nx       = cnt;
        sum          = acc + {2'b00, ctr};
`endif
        if (clear_i) begin
            // Clear wins over any edge or saturation in the same cycle.
            state_nx     = IDLE;
            ctr_nx       = '0;
            locked_nx    = 1'b0;
            timeout_nx   = 1'b0;
            have_prev_nx = 1'b0;
`ifdef PERIOD_METER_AVG_EN
            acc_nx       = '0;
            cnt_nx       = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (edge_det) begin
                        // Reference edge: start counting, nothing to report yet.
                        state_nx     = ARMED;
                        ctr_nx       = N'(1);
                        have_prev_nx = 1'b0;
                    end
                end
                ARMED: begin
                    if (edge_det) begin
                        // ctr equals the edge spacing here, including at CTR_MAX.
`ifdef PERIOD_METER_AVG_EN
                        locked_nx   = have_prev && (ctr == last_raw);
                        last_raw_nx = ctr;
                        if (cnt == 2'd3) begin
                            period_nx = sum[N+1:2];
                            valid_nx  = 1'b1;
                            acc_nx    = '0;
                            cnt_nx    = '0;
                        end else begin
                            acc_nx = sum;
                            cnt_nx = cnt + 2'd1;
                        end
`else
                        locked_nx = have_prev && (ctr == period_o);
                        period_nx = ctr;
                        valid_nx  = 1'b1;
`endif
                        have_prev_nx = 1'b1;
                        ctr_nx       = N'(1);
                    end else if (ctr == CTR_MAX) begin
                        // Saturated without an edge: give up, keep period_o.
                        state_nx     = IDLE;
                        ctr_nx       = '0;
                        timeout_nx   = 1'b1;
                        locked_nx    = 1'b0;
                        have_prev_nx = 1'b0;
`ifdef PERIOD_METER_AVG_EN
                        acc_nx       = '0;
                        cnt_nx       = '0;
`endif
                    end else begin
                        ctr_nx = ctr + N'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    ctr_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ctr       <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
            have_prev <= 1'b0;
            strobe_d  <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
            last_raw  <= '0;
            acc       <= '0;
            cnt       <= '0;
`endif
        end else begin
            state     <= state_nx;
            ctr       <= ctr_nx;
            period_o  <= period_nx;
            valid_o   <= valid_nx;
            locked_o  <= locked_nx;
            timeout_o <= timeout_nx;
            have_prev <= have_prev_nx;
            // Tracks strobe_i even during clear so a held level is not re-detected.
            strobe_d  <= strobe_i;
`ifdef PERIOD_METER_AVG_EN
            last_raw  <= last_raw_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
`endif
        end
    end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
Measures the spacing, in clk_i cycles, between rising edges of a strobe input. It is the receive-side counterpart of the tone clock generator: a strobe from a generator programmed with maxval M is reported back as period M. It sits on generator outputs for self-test and pitch readback, and on external trigger inputs for tempo and pitch detection. It provides a lock indication when consecutive periods match and a timeout when no edge arrives.

Parameters:
N, 16, width of the period counter and period_o; the maximum measurable period is 2^N-1 cycles.

Ports:
clk_i  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
strobe_i  input  1  strobe to measure, synchronous to clk_i
clear_i  input  1  synchronous clear: abort measurement, return to IDLE, clear flags
period_o  output  N  last measured period in clk_i cycles
valid_o  output  1  one-cycle pulse when period_o is updated
locked_o  output  1  high while the two most recent periods are equal
timeout_o  output  1  sticky; set on counter saturation

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset=0, every register clears immediately and independent of clk_i: period_o=0, valid_o=0, locked_o=0, timeout_o=0, state=IDLE, internal counter=0, strobe_d=0.
- Edge detection: strobe_d registers strobe_i each cycle. An edge is strobe_i=1 with strobe_d=0. A level held high counts as a single edge. The minimum detectable period is 2 cycles. A strobe that stays constantly high, such as a generator with maxval<=1, produces one edge and then a timeout.
- States:
  - IDLE: waiting for a reference edge. On an edge: ctr<=1, go to ARMED, no valid_o.
  - ARMED: ctr increments every cycle.
    - On an edge: period_o<=ctr, valid_o<=1 for exactly one cycle, ctr<=1, stay in ARMED.
    - If ctr==2^N-1 and no edge: timeout_o<=1, locked_o<=0, go to IDLE. period_o is kept and no valid_o is issued.
- Cycle accounting: edges P cycles apart give period_o=P. period_o and valid_o are registered on the clk_i edge that samples the second edge, so they are visible in the following cycle.
- Lock: when an edge is registered in ARMED, locked_o<=1 if the new period equals the previous period_o and a prior valid measurement exists since arming, otherwise locked_o<=0. Timeout and clear_i both drop locked_o.
- clear_i=1 has priority over everything in that cycle. It forces IDLE, ctr=0, locked_o=0, timeout_o=0 and valid_o=0; period_o is kept. An edge in the same cycle is ignored. strobe_d still updates, so a level that stays high afterwards does not create a new edge.
- An edge on the same cycle that ctr reaches 2^N-1 counts as a measurement (period 2^N-1), not a timeout.
- Widths: ctr is N bits, saturating and never wrapping. Comparisons are unsigned.

Optional Feature:
Macro PERIOD_METER_AVG_EN.
- Defined: adds an (N+2)-bit accumulator and a 2-bit count. Each raw measurement is added to the accumulator. On every 4th measurement, period_o<=sum>>2 (truncated) and valid_o pulses; the accumulator and count then clear. Timeout, clear_i and reset discard any partial block. locked_o still compares raw consecutive periods.
- Not defined: no accumulator; every measurement updates period_o and pulses valid_o.

Test Plan:
1. N=16, strobe pulses every 100 cycles. First edge: no valid_o. Second edge: period_o=100, valid_o high for one cycle. Third edge: period_o=100 and locked_o=1.
2. Locked at 100, then switch to spacing 37. Next valid_o gives period_o=37 with locked_o=0. The following edge sets locked_o=1 again.
3. N=8, one edge then idle for 300 cycles. timeout_o=1 and locked_o=0 after 255 counted cycles; period_o is unchanged. The next edge re-arms with no valid_o, and the edge after it gives the correct period.
4. strobe_i held high for 10 cycles, repeated every 50 cycles. period_o=50, with exactly one valid_o per 50 cycles.
5. Drop reset to 0 mid-count (asynchronous, between clock edges). All outputs are 0 immediately. Separately, assert clear_i on the same cycle as an edge: no valid_o, state IDLE, timeout_o cleared.
6. PERIOD_METER_AVG_EN defined, edge spacings 10, 11, 12, 13. A single valid_o after the 4th measurement with period_o=11 (46>>2). No valid_o for the first three measurements.
